// File: rtl/eth_sb_axi_req_bridge.sv
// Bridges one outstanding core request onto the sideband AXI master handshake,
// with per-attempt timeout, bounded SLVERR retry and local decode/fuse rejection.
module eth_sb_axi_req_bridge #(
  parameter int unsigned ADDR_WIDTH     = 24,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned MAX_RETRY      = 2,
  localparam int unsigned STRB_W        = DATA_WIDTH / 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_fuse_enable,
  input  logic                  i_dec_axi_en,
  input  logic                  i_core_valid,
  input  logic [ADDR_WIDTH-1:0] i_core_addr,
  input  logic [STRB_W-1:0]     i_core_wstrb,
  input  logic [DATA_WIDTH-1:0] i_core_wdata,
  output logic                  o_core_ready,
  output logic [DATA_WIDTH-1:0] o_core_rdata,
  output logic                  o_axi_mread,
  output logic                  o_axi_mwrite,
  output logic [ADDR_WIDTH-1:0] o_axi_maddr,
  output logic [DATA_WIDTH-1:0] o_axi_mdata,
  output logic [STRB_W-1:0]     o_axi_mwstrb,
  input  logic                  i_axi_saccept,
  output logic                  o_axi_mready,
  input  logic                  i_axi_svalid,
  input  logic [2:0]            i_axi_sresp,
  input  logic [DATA_WIDTH-1:0] i_axi_sdata,
  output logic                  o_axi_slverr,
  output logic                  o_axi_decoderr,
  output logic                  o_axi_timeout,
  output logic                  o_busy,
  output logic [3:0]            o_retry_count
);

  // Counter saturates above the limit so a late saccept cannot wrap it.
  localparam int unsigned TO_W     = $clog2(TIMEOUT_CYCLES + 2);
  localparam int unsigned TO_LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

  localparam logic [2:0] RESP_OKAY   = 3'b000;
  localparam logic [2:0] RESP_DECERR = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  slverr_q, slverr_d;
  logic                  decerr_q, decerr_d;
  logic                  timeout_q, timeout_d;
  logic [3:0]            retry_q, retry_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  mread_q, mread_d;
  logic                  mwrite_q, mwrite_d;
  logic                  mready_q, mready_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  to_hit;
  logic                  is_read;

  assign is_read = (wstrb_q == '0);
  assign to_hit  = TO_EN && (to_cnt_q >= TO_W'(TO_LIMIT));

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    slverr_d  = slverr_q;
    decerr_d  = decerr_q;
    timeout_d = timeout_q;
    retry_d   = retry_q;
    to_cnt_d  = to_cnt_q;

    case (state_q)
      IDLE: begin
        if (i_core_valid) begin
          addr_d    = i_core_addr;
          wdata_d   = i_core_wdata;
          wstrb_d   = i_core_wstrb;
          rdata_d   = '0;
          slverr_d  = 1'b0;
          decerr_d  = 1'b0;
          timeout_d = 1'b0;
          retry_d   = '0;
          if (!i_fuse_enable || !i_dec_axi_en) begin
            state_d  = DONE;
            decerr_d = 1'b1;
          end else begin
            state_d  = REQ;
            to_cnt_d = '0;
          end
        end
      end

      REQ: begin
        if (to_cnt_q != '1) to_cnt_d = to_cnt_q + TO_W'(1);
        if (i_axi_saccept) begin
          state_d = RESP;
        end else if (to_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          rdata_d   = '0;
        end
      end

      RESP: begin
        if (to_cnt_q != '1) to_cnt_d = to_cnt_q + TO_W'(1);
        if (i_axi_svalid) begin
          if (i_axi_sresp == RESP_OKAY) begin
            state_d = DONE;
            rdata_d = is_read ? i_axi_sdata : '0;
          end else if (i_axi_sresp == RESP_DECERR) begin
            state_d  = DONE;
            decerr_d = 1'b1;
            rdata_d  = '0;
          end else if (retry_q < 4'(MAX_RETRY)) begin
            // Any non-OKAY, non-DECERR code is retried as SLVERR.
            state_d  = REQ;
            retry_d  = retry_q + 4'd1;
            to_cnt_d = '0;
          end else begin
            state_d  = DONE;
            slverr_d = 1'b1;
            rdata_d  = '0;
          end
        end else if (to_hit) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          rdata_d   = '0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake outputs are registered from the next state so they line up with it.
  always_comb begin
    mread_d  = (state_d == REQ) && (wstrb_d == '0);
    mwrite_d = (state_d == REQ) && (wstrb_d != '0);
    mready_d = (state_d == RESP);
    ready_d  = (state_d == DONE);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      decerr_q  <= 1'b0;
      timeout_q <= 1'b0;
      retry_q   <= '0;
      to_cnt_q  <= '0;
      mread_q   <= 1'b0;
      mwrite_q  <= 1'b0;
      mready_q  <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      slverr_q  <= slverr_d;
      decerr_q  <= decerr_d;
      timeout_q <= timeout_d;
      retry_q   <= retry_d;
      to_cnt_q  <= to_cnt_d;
      mread_q   <= mread_d;
      mwrite_q  <= mwrite_d;
      mready_q  <= mready_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign o_core_ready   = ready_q;
  assign o_core_rdata   = rdata_q;
  assign o_axi_mread    = mread_q;
  assign o_axi_mwrite   = mwrite_q;
  assign o_axi_maddr    = addr_q;
  assign o_axi_mdata    = wdata_q;
  assign o_axi_mwstrb   = wstrb_q;
  assign o_axi_mready   = mready_q;
  assign o_axi_slverr   = slverr_q;
  assign o_axi_decoderr = decerr_q;
  assign o_axi_timeout  = timeout_q;
  assign o_busy         = busy_q;
  assign o_retry_count  = retry_q;

endmodule

// File: tb/tb_eth_sb_axi_req_bridge.sv
// Scoreboard bench for eth_sb_axi_req_bridge: expected completions are queued at
// request time and popped when o_core_ready pulses.
module tb_eth_sb_axi_req_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fuse_en, dec_en, core_valid;
  logic [23:0] core_addr;
  logic [3:0]  core_wstrb;
  logic [31:0] core_wdata;
  logic        o_core_ready;
  logic [31:0] o_core_rdata;
  logic        o_axi_mread, o_axi_mwrite;
  logic [23:0] o_axi_maddr;
  logic [31:0] o_axi_mdata;
  logic [3:0]  o_axi_mwstrb;
  logic        saccept, o_axi_mready, svalid;
  logic [2:0]  sresp;
  logic [31:0] sdata;
  logic        o_axi_slverr, o_axi_decoderr, o_axi_timeout, o_busy;
  logic [3:0]  o_retry_count;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_ready_cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  flags;   // {slverr, decoderr, timeout}
    logic [3:0]  retry;
    int          lat;
    int          issues;
  } exp_t;

  exp_t sb[$];

  eth_sb_axi_req_bridge #(
    .ADDR_WIDTH(24),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(8),
    .MAX_RETRY(2)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_fuse_enable(fuse_en),
    .i_dec_axi_en(dec_en),
    .i_core_valid(core_valid),
    .i_core_addr(core_addr),
    .i_core_wstrb(core_wstrb),
    .i_core_wdata(core_wdata),
    .o_core_ready(o_core_ready),
    .o_core_rdata(o_core_rdata),
    .o_axi_mread(o_axi_mread),
    .o_axi_mwrite(o_axi_mwrite),
    .o_axi_maddr(o_axi_maddr),
    .o_axi_mdata(o_axi_mdata),
    .o_axi_mwstrb(o_axi_mwstrb),
    .i_axi_saccept(saccept),
    .o_axi_mready(o_axi_mready),
    .i_axi_svalid(svalid),
    .i_axi_sresp(sresp),
    .i_axi_sdata(sdata),
    .o_axi_slverr(o_axi_slverr),
    .o_axi_decoderr(o_axi_decoderr),
    .o_axi_timeout(o_axi_timeout),
    .o_busy(o_busy),
    .o_retry_count(o_retry_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one request and plays the slave: saccept acc_dly cycles into each REQ
  // phase, svalid rsp_dly cycles into each RESP phase using resps[] in order.
  task automatic do_txn(input string name, input logic [23:0] addr, input logic [3:0] strb,
                        input logic [31:0] wd, input logic fuse, input logic dec,
                        input bit hold_valid, input int acc_dly, input int rsp_dly,
                        input logic [11:0] resps, input int nrsp, input logic [31:0] sd);
    exp_t e;
    int   lat, issues, acc_w, rsp_w, ridx;
    bit   prev_req, done;
    core_valid = 1'b1; core_addr = addr; core_wstrb = strb; core_wdata = wd;
    fuse_en = fuse; dec_en = dec; saccept = 1'b0; svalid = 1'b0;
    @(posedge clk); #1;
    if (!hold_valid) core_valid = 1'b0;
    lat = 1; issues = 0; acc_w = 0; rsp_w = 0; ridx = 0; prev_req = 1'b0; done = 1'b0;
    while (!done && lat < 64) begin
      saccept = 1'b0; svalid = 1'b0;
      if (o_core_ready === 1'b1) begin
        done = 1'b1;
        core_valid = 1'b0;
        last_ready_cyc = cyc;
      end else begin
        if ((o_axi_mread | o_axi_mwrite) === 1'b1) begin
          if (!prev_req) begin issues++; acc_w = 0; end
          checks++;
          if ({o_axi_maddr, o_axi_mdata, o_axi_mwstrb, o_axi_mread, o_axi_mwrite} !==
              {addr, wd, strb, (strb == 4'h0), (strb != 4'h0)}) begin
            failures++;
            $display("FAIL %s req_payload got a=%h d=%h s=%h r=%b w=%b want a=%h d=%h s=%h",
                     name, o_axi_maddr, o_axi_mdata, o_axi_mwstrb, o_axi_mread, o_axi_mwrite,
                     addr, wd, strb);
          end
          if (acc_w == acc_dly) saccept = 1'b1;
          acc_w++;
        end
        if (o_axi_mready === 1'b1) begin
          if (rsp_w == rsp_dly && ridx < nrsp) begin
            svalid = 1'b1;
            sresp  = resps[ridx*3 +: 3];
            sdata  = sd;
            ridx++;
            rsp_w  = 0;
          end else begin
            rsp_w++;
          end
        end else begin
          rsp_w = 0;
        end
        prev_req = (o_axi_mread | o_axi_mwrite);
        @(posedge clk); #1;
        lat++;
      end
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s no_ready got none within %0d cycles want o_core_ready", name, lat);
      core_valid = 1'b0;
      if (sb.size() != 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s sb_empty got ready with empty scoreboard want queued entry", name);
    end else begin
      e = sb.pop_front();
      checks++;
      if (o_core_rdata !== e.rdata) begin
        failures++; $display("FAIL %s rdata got %h want %h", name, o_core_rdata, e.rdata);
      end
      checks++;
      if ({o_axi_slverr, o_axi_decoderr, o_axi_timeout} !== e.flags) begin
        failures++;
        $display("FAIL %s flags got %b want %b", name,
                 {o_axi_slverr, o_axi_decoderr, o_axi_timeout}, e.flags);
      end
      checks++;
      if (o_retry_count !== e.retry) begin
        failures++; $display("FAIL %s retry got %0d want %0d", name, o_retry_count, e.retry);
      end
      checks++;
      if (lat != e.lat) begin
        failures++; $display("FAIL %s latency got %0d want %0d", name, lat, e.lat);
      end
      checks++;
      if (issues != e.issues) begin
        failures++; $display("FAIL %s issues got %0d want %0d", name, issues, e.issues);
      end
      @(posedge clk); #1;
      checks++;
      if ({o_core_ready, o_busy, o_axi_slverr, o_axi_decoderr, o_axi_timeout, o_retry_count} !==
          {2'b00, e.flags, e.retry}) begin
        failures++;
        $display("FAIL %s after_done got rdy=%b busy=%b flags=%b retry=%0d want 0 0 %b %0d",
                 name, o_core_ready, o_busy, {o_axi_slverr, o_axi_decoderr, o_axi_timeout},
                 o_retry_count, e.flags, e.retry);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fuse_en = 1'b0; dec_en = 1'b0; core_valid = 1'b0; core_addr = '0;
    core_wstrb = '0; core_wdata = '0; saccept = 1'b0; svalid = 1'b0; sresp = '0; sdata = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({o_core_ready, o_core_rdata, o_axi_mread, o_axi_mwrite, o_axi_maddr, o_axi_mdata,
         o_axi_mwstrb, o_axi_mready, o_axi_slverr, o_axi_decoderr, o_axi_timeout, o_busy,
         o_retry_count} !== '0) begin
      failures++; $display("FAIL reset_outputs got nonzero outputs want all zero");
    end
    rst_n = 1'b1; saccept = 1'b1; svalid = 1'b1; sdata = 32'hFFFF_FFFF;
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({o_busy, o_core_ready, o_axi_mread, o_axi_mwrite, o_axi_mready} !== 5'b0) begin
        failures++;
        $display("FAIL stray_idle got busy=%b rdy=%b rd=%b wr=%b mrdy=%b want 0",
                 o_busy, o_core_ready, o_axi_mread, o_axi_mwrite, o_axi_mready);
      end
    end
    saccept = 1'b0; svalid = 1'b0;
  endtask

  task automatic test_read();
    sb.push_back('{32'hDEAD_BEEF, 3'b000, 4'd0, 3, 1});
    do_txn("read", 24'h001234, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 0, 0, 12'o0000, 1, 32'hDEAD_BEEF);
    sb.push_back('{32'h0BAD_F00D, 3'b000, 4'd0, 6, 1});
    do_txn("read_slow", 24'hABCDEF, 4'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1, 2, 12'o0000, 1, 32'h0BAD_F00D);
  endtask

  task automatic test_write();
    sb.push_back('{32'h0, 3'b000, 4'd0, 6, 1});
    do_txn("write", 24'h005678, 4'hF, 32'hCAFE_BABE, 1'b1, 1'b1, 1'b1, 3, 0, 12'o0000, 1,
           32'h5555_AAAA);
    sb.push_back('{32'h0, 3'b000, 4'd0, 5, 1});
    do_txn("write_partial", 24'h000010, 4'h2, 32'h1122_3344, 1'b1, 1'b1, 1'b0, 0, 2, 12'o0000, 1,
           32'h7777_7777);
  endtask

  task automatic test_retry();
    // resps packs codes LSB-first: attempt 0 in [2:0], attempt 1 in [5:3], ...
    sb.push_back('{32'h1234_5678, 3'b000, 4'd2, 7, 3});
    do_txn("retry_ok", 24'h000100, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 0, 0, 12'o0044, 3, 32'h1234_5678);
    sb.push_back('{32'h0, 3'b100, 4'd2, 7, 3});
    do_txn("retry_exhaust", 24'h000104, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 0, 0, 12'o0444, 3,
           32'h9999_9999);
    sb.push_back('{32'h0, 3'b000, 4'd1, 5, 2});
    do_txn("retry_odd_code", 24'h000108, 4'h3, 32'hA5A5_5A5A, 1'b1, 1'b1, 1'b0, 0, 0, 12'o0003, 2,
           32'h4444_4444);
  endtask

  task automatic test_reject();
    sb.push_back('{32'h0, 3'b010, 4'd0, 1, 0});
    do_txn("reject_fuse", 24'h000200, 4'h0, 32'h0, 1'b0, 1'b1, 1'b1, 0, 0, 12'o0000, 1, 32'h1);
    sb.push_back('{32'h0, 3'b010, 4'd0, 1, 0});
    do_txn("reject_dec", 24'h000204, 4'hF, 32'h5, 1'b1, 1'b0, 1'b1, 0, 0, 12'o0000, 1, 32'h1);
    sb.push_back('{32'h0, 3'b010, 4'd0, 3, 1});
    do_txn("decerr", 24'h000208, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 0, 0, 12'o0006, 1, 32'h3333_3333);
  endtask

  task automatic test_timeout();
    sb.push_back('{32'h0, 3'b001, 4'd0, 9, 1});
    do_txn("timeout_resp", 24'h000300, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 0, 0, 12'o0000, 0, 32'h1);
    sb.push_back('{32'h8765_4321, 3'b000, 4'd0, 9, 1});
    do_txn("svalid_last", 24'h000304, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 0, 6, 12'o0000, 1,
           32'h8765_4321);
    sb.push_back('{32'h0, 3'b001, 4'd0, 9, 1});
    do_txn("timeout_req", 24'h000308, 4'hF, 32'h1, 1'b1, 1'b1, 1'b0, 20, 0, 12'o0000, 0, 32'h1);
    sb.push_back('{32'h0, 3'b001, 4'd1, 11, 2});
    do_txn("timeout_retry", 24'h00030C, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 0, 0, 12'o0004, 1, 32'h1);
  endtask

  task automatic test_reset_mid();
    core_valid = 1'b1; core_addr = 24'h000400; core_wstrb = 4'h0; fuse_en = 1'b1; dec_en = 1'b1;
    @(posedge clk); #1;
    core_valid = 1'b0; saccept = 1'b1;
    @(posedge clk); #1;
    saccept = 1'b0;
    checks++;
    if ({o_axi_mready, o_busy, o_axi_maddr} !== {2'b11, 24'h000400}) begin
      failures++;
      $display("FAIL mid_resp got mrdy=%b busy=%b a=%h want 1 1 000400",
               o_axi_mready, o_busy, o_axi_maddr);
    end
    #2; rst_n = 1'b0; #1;
    checks++;
    if ({o_core_ready, o_core_rdata, o_axi_mread, o_axi_mwrite, o_axi_maddr, o_axi_mdata,
         o_axi_mwstrb, o_axi_mready, o_axi_slverr, o_axi_decoderr, o_axi_timeout, o_busy,
         o_retry_count} !== '0) begin
      failures++; $display("FAIL async_reset got nonzero outputs want all zero");
    end
    @(posedge clk); #1;
    rst_n = 1'b1; svalid = 1'b1; sresp = 3'b000; sdata = 32'hEEEE_EEEE;
    repeat (2) begin
      @(posedge clk); #1;
      checks++;
      if ({o_busy, o_core_ready, o_core_rdata} !== 34'b0) begin
        failures++;
        $display("FAIL late_svalid got busy=%b rdy=%b rdata=%h want 0", o_busy, o_core_ready,
                 o_core_rdata);
      end
    end
    svalid = 1'b0;
    sb.push_back('{32'h0F0F_0F0F, 3'b000, 4'd0, 3, 1});
    do_txn("after_reset", 24'h000404, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 0, 0, 12'o0000, 1,
           32'h0F0F_0F0F);
  endtask

  task automatic test_back_to_back();
    int prev;
    sb.push_back('{32'h1111_1111, 3'b000, 4'd0, 3, 1});
    do_txn("b2b_0", 24'h000500, 4'h0, 32'h0, 1'b1, 1'b1, 1'b1, 0, 0, 12'o0000, 1, 32'h1111_1111);
    prev = last_ready_cyc;
    sb.push_back('{32'h2222_2222, 3'b000, 4'd0, 3, 1});
    do_txn("b2b_1", 24'h000504, 4'h0, 32'h0, 1'b1, 1'b1, 1'b1, 0, 0, 12'o0000, 1, 32'h2222_2222);
    checks++;
    if (last_ready_cyc - prev != 4) begin
      failures++;
      $display("FAIL b2b_spacing got %0d want 4", last_ready_cyc - prev);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_retry();
    test_reject();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got simulation still running want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
